// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: holds the program counter, reads one word at a time
// from a synchronous instruction memory and hands each word to the decoder
// over a registered valid/ready interface. Stops fetching after a HALT word.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } fetchState_t;

    localparam logic [5:0] HALT_OPCODE = 6'b010110;

    fetchState_t r_state;
    fetchState_t w_nextState;

    logic [31:0] r_pc;
    logic [31:0] r_ins;
    logic [31:0] r_insPc;
    logic        r_insValid;

    logic [31:0] w_redirectTarget;
    logic        w_isHalt;

    // Redirect targets are word-aligned by clearing the two low address bits.
    assign w_redirectTarget = redirect_pc & 32'hFFFF_FFFC;
    assign w_isHalt         = (imem_rdata[31:26] == HALT_OPCODE);

    assign imem_en   = (r_state == ST_REQ) && !rst;
    assign imem_addr = r_pc;
    assign ins       = r_ins;
    assign ins_pc    = r_insPc;
    assign ins_valid = r_insValid;
    assign halted    = (r_state == ST_HALTED);

    // State register; reset has priority over redirect and everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_REQ;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: a redirect flushes back to REQ from any active state,
    // while HALTED ignores redirects and only leaves through reset.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_REQ: begin
                if (redirect) begin
                    w_nextState = ST_REQ;
                end else begin
                    w_nextState = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    w_nextState = ST_REQ;
                end else if (w_isHalt) begin
                    w_nextState = ST_HALTED;
                end else begin
                    w_nextState = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    w_nextState = ST_REQ;
                end else if (ins_ready) begin
                    w_nextState = ST_REQ;
                end else begin
                    w_nextState = ST_HOLD;
                end
            end
            ST_HALTED: begin
                w_nextState = ST_HALTED;
            end
            default: begin
                w_nextState = ST_REQ;
            end
        endcase
    end

    // PC and decoder-facing registers: capture memory data in WAIT, hold it
    // until the decoder takes it, and drop everything on a redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_ins      <= 32'h0;
            r_insPc    <= 32'h0;
            r_insValid <= 1'b0;
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (redirect) begin
                        r_pc       <= w_redirectTarget;
                        r_insValid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (redirect) begin
                        r_pc       <= w_redirectTarget;
                        r_insValid <= 1'b0;
                    end else begin
                        r_ins      <= imem_rdata;
                        r_insPc    <= r_pc;
                        r_insValid <= 1'b1;
                        r_pc       <= r_pc + 32'd4;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        r_pc       <= w_redirectTarget;
                        r_insValid <= 1'b0;
                    end else if (ins_ready) begin
                        r_insValid <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    if (ins_ready) begin
                        r_insValid <= 1'b0;
                    end
                end
                default: begin
                    r_insValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed test of the fetch unit against a small
// synchronous memory model (word at address A holds A, except 0xC holds HALT).
// A second instance starts at 0xFFFF_FFFC to exercise PC wrap-around.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        insReady = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectPc = 32'h0;

    logic        imemEn;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata = 32'h0;
    logic [31:0] ins;
    logic [31:0] insPc;
    logic        insValid;
    logic        halted;

    logic        wrapImemEn;
    logic [31:0] wrapImemAddr;
    logic [31:0] wrapImemRdata = 32'h0;
    logic [31:0] wrapIns;
    logic [31:0] wrapInsPc;
    logic        wrapInsValid;
    logic        wrapHalted;

    int checksTotal  = 0;
    int checksPassed = 0;

    instruction_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .imem_en    (imemEn),
        .imem_addr  (imemAddr),
        .imem_rdata (imemRdata),
        .ins        (ins),
        .ins_pc     (insPc),
        .ins_valid  (insValid),
        .ins_ready  (insReady),
        .redirect   (redirect),
        .redirect_pc(redirectPc),
        .halted     (halted)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk        (clk),
        .rst        (rst),
        .imem_en    (wrapImemEn),
        .imem_addr  (wrapImemAddr),
        .imem_rdata (wrapImemRdata),
        .ins        (wrapIns),
        .ins_pc     (wrapInsPc),
        .ins_valid  (wrapInsValid),
        .ins_ready  (insReady),
        .redirect   (redirect),
        .redirect_pc(redirectPc),
        .halted     (wrapHalted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        if (addr == 32'h0000_000C) begin
            return 32'h5800_0000;
        end
        return addr;
    endfunction

    // Synchronous instruction memories: data appears the cycle after the request.
    always @(posedge clk) begin
        if (imemEn) imemRdata <= memWord(imemAddr);
        if (wrapImemEn) wrapImemRdata <= memWord(wrapImemAddr);
    end

    // Drive one cycle's inputs just after the rising edge, then settle before checks.
    task automatic applyStimulus(input logic r, input logic rdy, input logic redir,
                                 input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst        = r;
        insReady   = rdy;
        redirect   = redir;
        redirectPc = rpc;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checksTotal++;
        assert (observed === expected) checksPassed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic resetUnit();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        // Reset state.
        resetUnit();
        checkOutput("reset ins_valid", insValid, 0);
        checkOutput("reset ins", ins, 0);
        checkOutput("reset ins_pc", insPc, 0);
        checkOutput("reset halted", halted, 0);
        checkOutput("reset imem_en", imemEn, 0);
        checkOutput("reset imem_addr", imemAddr, 32'h0);

        // Sequential fetch with ready high: REQ/WAIT/HOLD every 3 cycles.
        for (int c = 0; c <= 8; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            checkOutput($sformatf("seq c%0d imem_en", c), imemEn, (c % 3 == 0));
            checkOutput($sformatf("seq c%0d ins_valid", c), insValid, (c % 3 == 2));
            if (c % 3 == 0) checkOutput($sformatf("seq c%0d imem_addr", c), imemAddr, (c / 3) * 4);
            if (c % 3 == 2) begin
                checkOutput($sformatf("seq c%0d ins", c), ins, (c / 3) * 4);
                checkOutput($sformatf("seq c%0d ins_pc", c), insPc, (c / 3) * 4);
            end
            if (c == 0) checkOutput("wrap first addr", wrapImemAddr, 32'hFFFF_FFFC);
            if (c == 2) checkOutput("wrap first ins_pc", wrapInsPc, 32'hFFFF_FFFC);
            if (c == 3) begin
                checkOutput("wrap second en", wrapImemEn, 1);
                checkOutput("wrap second addr", wrapImemAddr, 32'h0);
            end
        end

        // Backpressure on the word at 0x4.
        resetUnit();
        for (int c = 0; c <= 4; c++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int c = 5; c <= 9; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            checkOutput($sformatf("bp c%0d ins_valid", c), insValid, 1);
            checkOutput($sformatf("bp c%0d ins", c), ins, 32'h4);
            checkOutput($sformatf("bp c%0d ins_pc", c), insPc, 32'h4);
            checkOutput($sformatf("bp c%0d imem_en", c), imemEn, 0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("bp release imem_en", imemEn, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("bp next imem_en", imemEn, 1);
        checkOutput("bp next imem_addr", imemAddr, 32'h8);
        checkOutput("bp next ins_valid", insValid, 0);

        // Redirect during REQ (cycle 0).
        resetUnit();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0103);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("rdReq imem_en", imemEn, 1);
        checkOutput("rdReq imem_addr", imemAddr, 32'h100);
        checkOutput("rdReq ins_valid", insValid, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("rdReq wait ins_valid", insValid, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("rdReq ins_valid", insValid, 1);
        checkOutput("rdReq ins_pc", insPc, 32'h100);
        checkOutput("rdReq ins", ins, 32'h100);

        // Redirect during WAIT while the in-flight word is the HALT at 0xC.
        resetUnit();
        for (int c = 0; c <= 9; c++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("rdWait pre addr", imemAddr, 32'hC);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0103);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("rdWait imem_en", imemEn, 1);
        checkOutput("rdWait imem_addr", imemAddr, 32'h100);
        checkOutput("rdWait ins_valid", insValid, 0);
        checkOutput("rdWait halted", halted, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("rdWait ins_valid", insValid, 1);
        checkOutput("rdWait ins_pc", insPc, 32'h100);
        checkOutput("rdWait halted late", halted, 0);

        // Redirect during HOLD with ready high: redirect wins.
        resetUnit();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0103);
        checkOutput("rdHold held ins_pc", insPc, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("rdHold imem_en", imemEn, 1);
        checkOutput("rdHold imem_addr", imemAddr, 32'h100);
        checkOutput("rdHold ins_valid", insValid, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("rdHold ins_pc", insPc, 32'h100);
        checkOutput("rdHold ins_valid", insValid, 1);

        // HALT at 0xC: delivered, halted, redirect ignored, reset recovers.
        resetUnit();
        for (int c = 0; c <= 10; c++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("halt halted", halted, 1);
        checkOutput("halt ins_valid", insValid, 1);
        checkOutput("halt ins", ins, 32'h5800_0000);
        checkOutput("halt ins_pc", insPc, 32'hC);
        checkOutput("halt imem_en", imemEn, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0103);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("halt redirect ignored halted", halted, 1);
        checkOutput("halt redirect ignored en", imemEn, 0);
        checkOutput("halt still valid", insValid, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("halt consumed valid", insValid, 0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            checkOutput($sformatf("halt idle%0d en", c), imemEn, 0);
            checkOutput($sformatf("halt idle%0d halted", c), halted, 1);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("halt reset halted", halted, 0);
        checkOutput("halt reset en", imemEn, 1);
        checkOutput("halt reset addr", imemAddr, 32'h0);

        // Mid-operation reset during WAIT.
        resetUnit();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("midRst wait en", imemEn, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("midRst ins_valid", insValid, 0);
        checkOutput("midRst imem_en", imemEn, 0);
        checkOutput("midRst ins", ins, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("midRst restart en", imemEn, 1);
        checkOutput("midRst restart addr", imemAddr, 32'h0);
        checkOutput("midRst restart valid", insValid, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("midRst wait valid", insValid, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("midRst fresh valid", insValid, 1);
        checkOutput("midRst fresh ins_pc", insPc, 32'h0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
